// File: rtl/debug_pkg.sv
// debug_pkg: definitions shared by the JTAG debug return path and the
// command-path controller.
//   - DEBUGOP_* opcodes carried on the synchronized debug op bus
//   - STAT_* bit positions inside the published status byte
//   - state_e: read-back FSM states
package debug_pkg;

  localparam logic [7:0] DEBUGOP_STORE_IADDR = 8'h80;
  localparam logic [7:0] DEBUGOP_STORE_DADDR = 8'h82;
  localparam logic [7:0] DEBUGOP_READIMEM    = 8'h04;
  localparam logic [7:0] DEBUGOP_READDMEM    = 8'h06;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_TIMEOUT = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int STAT_SPACE   = 3;
  localparam int STAT_CNT_LSB = 4;  // [7:4] publication count mod 16

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/debug_readback_if.sv
// debug_readback_if: bundles the debug op input, the memory read port and the
// response publication signals of debug_readback.
//   slave  : the debug_readback side (consumes ops and read data, drives
//            mem requests and the response)
//   master : the environment side (op source, memory, TAP capture)
interface debug_readback_if #(
  parameter int ADDR_WIDTH = 32
) ();
  import debug_pkg::*;

  logic                  op_valid;
  logic [7:0]            op;
  logic [31:0]           op_data;
  logic                  mem_req;
  logic                  mem_sel;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  logic [31:0]           resp_data;
  logic [7:0]            resp_status;
  logic                  resp_toggle;

  modport slave (
    input  op_valid, op, op_data, mem_rvalid, mem_rdata,
    output mem_req, mem_sel, mem_addr, resp_data, resp_status, resp_toggle
  );

  modport master (
    output op_valid, op, op_data, mem_rvalid, mem_rdata,
    input  mem_req, mem_sel, mem_addr, resp_data, resp_status, resp_toggle
  );
endinterface

// File: rtl/debug_readback.sv
// debug_readback: JTAG debug return-path engine (CPU clock domain).
// Accepts synchronized single-cycle debug ops, issues an imem/dmem read,
// and publishes the returned word (or TIMEOUT_DATA) together with a status
// byte and a toggle the TAP synchronizes back into the JTAG domain.
// Ports:
//   clk   - CPU clock, rising edge
//   rst_p - synchronous active-high reset
//   bus   - debug_readback_if.slave: op_valid/op/op_data in,
//           mem_req/mem_sel/mem_addr out, mem_rvalid/mem_rdata in,
//           resp_data/resp_status/resp_toggle out
module debug_readback
  import debug_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_DEAD
) (
  input  logic clk,
  input  logic rst_p,
  debug_readback_if.slave bus
);

  localparam logic [7:0]            TMO_LIMIT = 8'(TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_iaddr, r_daddr;
  logic                  r_sel;       // space of the read in flight
  logic [7:0]            r_tmo_cnt;
  logic                  r_mem_req, r_mem_sel;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_resp_data;
  logic                  r_toggle;
  logic                  r_busy, r_tmo, r_ovr, r_space;
  logic [3:0]            r_pub_cnt;

  always_ff @(posedge clk) begin
    if (rst_p) begin
      r_state     <= ST_IDLE;
      r_iaddr     <= '0;
      r_daddr     <= '0;
      r_sel       <= 1'b0;
      r_tmo_cnt   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_sel   <= 1'b0;
      r_mem_addr  <= '0;
      r_resp_data <= '0;
      r_toggle    <= 1'b0;
      r_busy      <= 1'b0;
      r_tmo       <= 1'b0;
      r_ovr       <= 1'b0;
      r_space     <= 1'b0;
      r_pub_cnt   <= '0;
    end else begin
      r_mem_req <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              DEBUGOP_STORE_IADDR: r_iaddr <= bus.op_data[ADDR_WIDTH-1:0];
              DEBUGOP_STORE_DADDR: r_daddr <= bus.op_data[ADDR_WIDTH-1:0];
              DEBUGOP_READIMEM, DEBUGOP_READDMEM: begin
                r_sel   <= (bus.op == DEBUGOP_READDMEM);
                r_ovr   <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= ST_ISSUE;
              end
              default: ;
            endcase
          end
        end
        ST_ISSUE: begin
          r_mem_req  <= 1'b1;
          r_mem_sel  <= r_sel;
          r_mem_addr <= r_sel ? r_daddr : r_iaddr;
          r_tmo_cnt  <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // Data arriving in the expiry cycle takes priority over the timeout.
          if (bus.mem_rvalid || (r_tmo_cnt == TMO_LIMIT)) begin
            r_resp_data <= bus.mem_rvalid ? bus.mem_rdata : TIMEOUT_DATA;
            r_tmo       <= ~bus.mem_rvalid;
            r_toggle    <= ~r_toggle;
            r_pub_cnt   <= r_pub_cnt + 4'd1;
            r_space     <= r_sel;
            r_busy      <= 1'b0;
            if (r_sel) r_daddr <= r_daddr + ADDR_ONE;
            else       r_iaddr <= r_iaddr + ADDR_ONE;
            r_state     <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Ops arriving while a read is in flight are dropped, stores included.
      if (bus.op_valid && (r_state != ST_IDLE)) r_ovr <= 1'b1;
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_sel     = r_mem_sel;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.resp_data   = r_resp_data;
  assign bus.resp_toggle = r_toggle;
  assign bus.resp_status = {r_pub_cnt, r_space, r_ovr, r_tmo, r_busy};

endmodule
